// File: rtl/prbs_pattern_gen.sv
// prbs_pattern_gen
// Emits a fixed 4-byte frame pattern n_pattern times, then a PRBS-15
// byte stream, one byte per clock, until EN drops.
//
// Parameters:
//   SEED  - PRBS-15 LFSR load value (must be non-zero)
//   P0-P3 - frame pattern bytes in transmit order
//
// Ports:
//   CLK          in   single clock, rising-edge active
//   RST          in   asynchronous active-low reset
//   START        in   one-cycle request to begin a transmission (IDLE only)
//   EN           in   level enable; low aborts a transmission
//   n_pattern    in   number of 4-byte pattern repetitions before PRBS
//   OUT          out  transmitted byte, registered
//   OUT_VALID    out  high while OUT carries a transmitted byte
//   PATTERN_DONE out  one-cycle pulse with the first PRBS byte
module prbs_pattern_gen #(
    parameter logic [14:0] SEED = 15'h7FFF,
    parameter logic [7:0]  P0   = 8'h10,
    parameter logic [7:0]  P1   = 8'hAB,
    parameter logic [7:0]  P2   = 8'hCD,
    parameter logic [7:0]  P3   = 8'hEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       EN,
    input  logic [7:0] n_pattern,
    output logic [7:0] OUT,
    output logic       OUT_VALID,
    output logic       PATTERN_DONE
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PATTERN = 2'd1;
    localparam logic [1:0] ST_PRBS    = 2'd2;

    logic [1:0]  state;
    logic [1:0]  byte_idx;
    logic [7:0]  rep_cnt;
    logic [7:0]  n_lat;
    logic [14:0] lfsr;

    logic [14:0] lfsr_adv;
    logic [14:0] seed_adv;
    logic [7:0]  rep_inc;
    logic [1:0]  idx_inc;

    // Eight serial LFSR steps (new = L[14]^L[13], shifted in at bit 0).
    // After eight shifts the generated bits sit in [7:0] with the first
    // generated bit in bit 7, which is exactly the byte order we transmit.
    function automatic logic [14:0] lfsr_step8(input logic [14:0] s);
        logic [14:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[13:0], t[14] ^ t[13]};
        end
        return t;
    endfunction

    function automatic logic [7:0] pattern_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = P0;
            2'd1:    b = P1;
            2'd2:    b = P2;
            default: b = P3;
        endcase
        return b;
    endfunction

    assign lfsr_adv = lfsr_step8(lfsr);
    assign seed_adv = lfsr_step8(SEED);
    assign rep_inc  = rep_cnt + 8'd1;
    assign idx_inc  = byte_idx + 2'd1;

    // Main sequencer. Outputs are produced directly from registers so the
    // byte chosen at an edge is what appears on OUT for the whole next
    // cycle. byte_idx always names the pattern byte currently on OUT, so
    // the transition to PRBS happens on the edge that leaves the last P3.
    // When n_pattern is zero the first PRBS byte is generated straight
    // from SEED at the START edge so no pattern cycle is emitted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= ST_IDLE;
            byte_idx     <= 2'd0;
            rep_cnt      <= 8'd0;
            n_lat        <= 8'd0;
            lfsr         <= SEED;
            OUT          <= 8'h00;
            OUT_VALID    <= 1'b0;
            PATTERN_DONE <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    OUT          <= 8'h00;
                    OUT_VALID    <= 1'b0;
                    PATTERN_DONE <= 1'b0;
                    if (START && EN) begin
                        n_lat     <= n_pattern;
                        byte_idx  <= 2'd0;
                        rep_cnt   <= 8'd0;
                        OUT_VALID <= 1'b1;
                        if (n_pattern == 8'd0) begin
                            state        <= ST_PRBS;
                            lfsr         <= seed_adv;
                            OUT          <= seed_adv[7:0];
                            PATTERN_DONE <= 1'b1;
                        end else begin
                            state <= ST_PATTERN;
                            lfsr  <= SEED;
                            OUT   <= P0;
                        end
                    end
                end

                ST_PATTERN: begin
                    if (!EN) begin
                        state        <= ST_IDLE;
                        byte_idx     <= 2'd0;
                        rep_cnt      <= 8'd0;
                        OUT          <= 8'h00;
                        OUT_VALID    <= 1'b0;
                        PATTERN_DONE <= 1'b0;
                    end else if (byte_idx == 2'd3) begin
                        rep_cnt  <= rep_inc;
                        byte_idx <= 2'd0;
                        if (rep_inc == n_lat) begin
                            state        <= ST_PRBS;
                            lfsr         <= lfsr_adv;
                            OUT          <= lfsr_adv[7:0];
                            PATTERN_DONE <= 1'b1;
                        end else begin
                            OUT <= P0;
                        end
                    end else begin
                        byte_idx <= idx_inc;
                        OUT      <= pattern_byte(idx_inc);
                    end
                end

                ST_PRBS: begin
                    if (!EN) begin
                        state        <= ST_IDLE;
                        byte_idx     <= 2'd0;
                        rep_cnt      <= 8'd0;
                        OUT          <= 8'h00;
                        OUT_VALID    <= 1'b0;
                        PATTERN_DONE <= 1'b0;
                    end else begin
                        lfsr         <= lfsr_adv;
                        OUT          <= lfsr_adv[7:0];
                        OUT_VALID    <= 1'b1;
                        PATTERN_DONE <= 1'b0;
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    byte_idx     <= 2'd0;
                    rep_cnt      <= 8'd0;
                    OUT          <= 8'h00;
                    OUT_VALID    <= 1'b0;
                    PATTERN_DONE <= 1'b0;
                end
            endcase
        end
    end

endmodule
